// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus arbiter slice.
// The arbitration policy is selected with the RTC_ARB_RR_EN macro in rtc_bus_arbiter.sv.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_A_SU = 3'd1,
        ST_A_ST = 3'd2,
        ST_A_HD = 3'd3,
        ST_D_SU = 3'd4,
        ST_D_ST = 3'd5,
        ST_D_HD = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    localparam logic ID_MENU    = 1'b0;
    localparam logic ID_REFRESH = 1'b1;

    typedef struct packed {
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       ad_n;
        logic       ad_oe;
        logic [7:0] ad_out;
    } pins_t;

    // Bus levels while no transaction is in flight
    localparam pins_t PINS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                    ad_n: 1'b1, ad_oe: 1'b0, ad_out: 8'h00};

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter used to time each bus phase; zero is high when the count is exhausted.
module rtc_phase_timer #(
    parameter int unsigned W = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Two-requester arbiter and transaction sequencer for the RTC multiplexed AD bus.
// Define RTC_ARB_RR_EN for round-robin tie-breaking; otherwise req0 has fixed priority.
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 4,
    parameter int unsigned T_HOLD  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       AD_n,
    output logic [7:0] AD_out,
    output logic       AD_oe,
    input  logic [7:0] AD_in
);

    localparam int unsigned CW = $clog2(max3(T_SETUP, T_PULSE, T_HOLD) + 1);

    state_t       state_q, state_d;
    logic         grant_q, grant_d;
    logic         we_q, we_d;
    logic [7:0]   addr_q, addr_d;
    logic [7:0]   wdata_q, wdata_d;
    logic         win;
    pins_t        pins_q, pins_d;
    logic [7:0]   cap_q;
    logic [7:0]   rdata_q;
    logic         done0_q, done1_q, busy_q;
    logic         t_load, t_zero;
    logic [CW-1:0] t_val;

`ifdef RTC_ARB_RR_EN
    logic last_q;

    always_comb begin
        win = ID_MENU;
        if (req0 && req1) win = ~last_q;
        else if (req1)    win = ID_REFRESH;
    end

    always_ff @(posedge CLK) begin
        if (RST)                                        last_q <= 1'b1;
        else if (state_q == ST_IDLE && state_d != ST_IDLE) last_q <= grant_d;
    end
`else
    always_comb begin
        win = req0 ? ID_MENU : ID_REFRESH;
    end
`endif

    rtc_phase_timer #(.W(CW)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: if (req0 || req1) begin
                state_d = ST_A_SU;
                grant_d = win;
                we_d    = (win == ID_REFRESH) ? we1    : we0;
                addr_d  = (win == ID_REFRESH) ? addr1  : addr0;
                wdata_d = (win == ID_REFRESH) ? wdata1 : wdata0;
            end
            ST_A_SU: if (t_zero) state_d = ST_A_ST;
            ST_A_ST: if (t_zero) state_d = ST_A_HD;
            ST_A_HD: if (t_zero) state_d = ST_D_SU;
            ST_D_SU: if (t_zero) state_d = ST_D_ST;
            ST_D_ST: if (t_zero) state_d = ST_D_HD;
            ST_D_HD: if (t_zero) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        t_load = (state_d != state_q);
        case (state_d)
            ST_A_SU, ST_D_SU: t_val = CW'(T_SETUP - 1);
            ST_A_ST, ST_D_ST: t_val = CW'(T_PULSE - 1);
            ST_A_HD, ST_D_HD: t_val = CW'(T_HOLD - 1);
            default:          t_val = '0;
        endcase
    end

    // Pin values are decoded from the next state so the registered pins line up with the state
    always_comb begin
        pins_d = pins_q;
        case (state_d)
            ST_A_SU, ST_A_ST, ST_A_HD: begin
                pins_d.cs_n   = 1'b0;
                pins_d.ad_n   = 1'b0;
                pins_d.ad_oe  = 1'b1;
                pins_d.ad_out = addr_d;
                pins_d.rd_n   = 1'b1;
                pins_d.wr_n   = (state_d != ST_A_ST);
            end
            ST_D_SU, ST_D_ST, ST_D_HD: begin
                pins_d.cs_n  = 1'b0;
                pins_d.ad_n  = 1'b1;
                pins_d.ad_oe = we_d;
                if (we_d) pins_d.ad_out = wdata_d;
                pins_d.wr_n  = !(state_d == ST_D_ST && we_d);
                pins_d.rd_n  = !(state_d == ST_D_ST && !we_d);
            end
            default: begin
                pins_d.cs_n  = 1'b1;
                pins_d.ad_n  = 1'b1;
                pins_d.ad_oe = 1'b0;
                pins_d.rd_n  = 1'b1;
                pins_d.wr_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            grant_q <= ID_MENU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pins_q  <= PINS_IDLE;
            cap_q   <= '0;
            rdata_q <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pins_q  <= pins_d;
            if (state_q == ST_D_ST && t_zero && !we_q) cap_q <= AD_in;
            if (state_d == ST_DONE && !we_q)           rdata_q <= cap_q;
            done0_q <= (state_d == ST_DONE) && (grant_d == ID_MENU);
            done1_q <= (state_d == ST_DONE) && (grant_d == ID_REFRESH);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign CS_n   = pins_q.cs_n;
    assign RD_n   = pins_q.rd_n;
    assign WR_n   = pins_q.wr_n;
    assign AD_n   = pins_q.ad_n;
    assign AD_oe  = pins_q.ad_oe;
    assign AD_out = pins_q.ad_out;
    assign rdata  = rdata_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign busy   = busy_q;

endmodule
